// File: rtl/trace_capture_buffer_if.sv
// rtl/trace_capture_buffer_if.sv - trace entry input and readout bundle for trace_capture_buffer
// master drives trace entries and read pops; slave is the capture buffer.
interface trace_capture_buffer_if #(
  parameter int DATA_W = 32
);
  logic              tr_valid;
  logic [31:0]       tr_instr;
  logic [4:0]        tr_wreg;
  logic [DATA_W-1:0] tr_wdata;
  logic              rd_en;
  logic              rd_valid;
  logic [31:0]       rd_instr;
  logic [4:0]        rd_wreg;
  logic [DATA_W-1:0] rd_wdata;
  logic              rd_empty;

  modport master (
    output tr_valid, tr_instr, tr_wreg, tr_wdata, rd_en,
    input  rd_valid, rd_instr, rd_wreg, rd_wdata, rd_empty
  );

  modport slave (
    input  tr_valid, tr_instr, tr_wreg, tr_wdata, rd_en,
    output rd_valid, rd_instr, rd_wreg, rd_wdata, rd_empty
  );
endinterface

// File: rtl/trace_capture_buffer.sv
// rtl/trace_capture_buffer.sv - circular retire-trace buffer with opcode trigger and oldest-first readout
// Optional per-entry cycle timestamp and rd_ts output when TRACE_TIMESTAMP_EN is defined.
module trace_capture_buffer #(
  parameter int DATA_W    = 32,
  parameter int ADDR_W    = 3,
  parameter int POST_TRIG = 3,
  parameter int TS_W      = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 arm,
  input  logic [5:0]           trig_op,
  input  logic [5:0]           trig_mask,
  trace_capture_buffer_if.slave bus,
  output logic [1:0]           state,
  output logic [ADDR_W:0]      count,
  output logic [ADDR_W-1:0]    trig_pos
`ifdef TRACE_TIMESTAMP_EN
  ,
  output logic [TS_W-1:0]      rd_ts
`endif
);

  localparam int DEPTH = 1 << ADDR_W;
  localparam logic [ADDR_W:0]   DEPTH_C = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W-1:0] POST_C  = ADDR_W'(POST_TRIG);
`ifdef TRACE_TIMESTAMP_EN
  localparam int ENTRY_W = 37 + DATA_W + TS_W;
`else
  localparam int ENTRY_W = 37 + DATA_W;
`endif

  typedef enum logic [1:0] {
    S_IDLE  = 2'b00,
    S_ARMED = 2'b01,
    S_POST  = 2'b10,
    S_DONE  = 2'b11
  } state_t;

  state_t              state_q, state_d;
  logic [ENTRY_W-1:0]  mem [DEPTH];
  logic [ENTRY_W-1:0]  wr_entry;
  logic [ENTRY_W-1:0]  rd_entry;
  logic [ADDR_W-1:0]   wr_ptr;
  logic [ADDR_W-1:0]   post_cnt;
  logic [ADDR_W-1:0]   rd_addr;
  logic [ADDR_W:0]     rd_idx;
  logic [ADDR_W:0]     count_q;
  logic [ADDR_W-1:0]   trig_pos_q;
  logic                do_arm, wr_en, hit, full, rd_fire;

  assign do_arm  = arm && (state_q == S_IDLE || state_q == S_DONE);
  assign wr_en   = bus.tr_valid && (state_q == S_ARMED || state_q == S_POST);
  assign hit     = bus.tr_valid && (((bus.tr_instr[31:26] ^ trig_op) & trig_mask) == 6'd0);
  assign full    = (count_q == DEPTH_C);
  // arm takes priority over a same-cycle pop in DONE
  assign rd_fire = (state_q == S_DONE) && bus.rd_en && !arm && (rd_idx != count_q);
  assign rd_addr = wr_ptr - count_q[ADDR_W-1:0] + rd_idx[ADDR_W-1:0];

`ifdef TRACE_TIMESTAMP_EN
  logic [TS_W-1:0] ts;
  always_ff @(posedge clk) begin
    if (reset) ts <= '0;
    else       ts <= ts + TS_W'(1);
  end
  assign wr_entry = {ts, bus.tr_instr, bus.tr_wreg, bus.tr_wdata};
`else
  assign wr_entry = {bus.tr_instr, bus.tr_wreg, bus.tr_wdata};
`endif

  assign rd_entry = mem[rd_addr];

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr] <= wr_entry;
  end

  always_ff @(posedge clk) begin
    if (reset) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (arm) state_d = S_ARMED;
      S_ARMED: if (wr_en && hit) state_d = (POST_TRIG == 0) ? S_DONE : S_POST;
      S_POST:  if (wr_en && post_cnt == ADDR_W'(1)) state_d = S_DONE;
      S_DONE:  if (arm) state_d = S_ARMED;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr       <= '0;
      count_q      <= '0;
      rd_idx       <= '0;
      post_cnt     <= '0;
      trig_pos_q   <= '0;
      bus.rd_valid <= 1'b0;
      bus.rd_instr <= '0;
      bus.rd_wreg  <= '0;
      bus.rd_wdata <= '0;
`ifdef TRACE_TIMESTAMP_EN
      rd_ts        <= '0;
`endif
    end else begin
      bus.rd_valid <= 1'b0;
      if (do_arm) begin
        wr_ptr     <= '0;
        count_q    <= '0;
        rd_idx     <= '0;
        post_cnt   <= '0;
        trig_pos_q <= '0;
      end else begin
        if (wr_en) begin
          wr_ptr <= wr_ptr + ADDR_W'(1);
          if (!full) count_q <= count_q + (ADDR_W+1)'(1);
          // trigger index is measured from the oldest entry after this write lands
          if (state_q == S_ARMED && hit) begin
            post_cnt   <= POST_C;
            trig_pos_q <= full ? ADDR_W'(DEPTH - 1) : count_q[ADDR_W-1:0];
          end else if (state_q == S_POST) begin
            post_cnt <= post_cnt - ADDR_W'(1);
            if (full) trig_pos_q <= trig_pos_q - ADDR_W'(1);
          end
        end
        if (rd_fire) begin
          bus.rd_valid <= 1'b1;
          bus.rd_wdata <= rd_entry[DATA_W-1:0];
          bus.rd_wreg  <= rd_entry[DATA_W+4:DATA_W];
          bus.rd_instr <= rd_entry[DATA_W+36:DATA_W+5];
`ifdef TRACE_TIMESTAMP_EN
          rd_ts        <= rd_entry[ENTRY_W-1:DATA_W+37];
`endif
          rd_idx       <= rd_idx + (ADDR_W+1)'(1);
        end
      end
    end
  end

  assign bus.rd_empty = (state_q == S_DONE) && (rd_idx == count_q);
  assign state        = state_q;
  assign count        = count_q;
  assign trig_pos     = trig_pos_q;

endmodule
